// File: rtl/fir_mac_serial_if.sv
// Sample, coefficient-load and result signals of the serial-MAC FIR filter.
// master = sample source / coefficient writer / DAC side, slave = filter.
interface fir_mac_serial_if #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 12,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 16
);
    logic                     ext_strobe;
    logic                     strobe_out;
    logic [DATA_W-1:0]        din;
    logic                     coef_we;
    logic [$clog2(NTAPS)-1:0] coef_addr;
    logic [COEF_W-1:0]        coef_wdata;
    logic                     coef_ack;
    logic [OUT_W-1:0]         dout;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;
    logic                     overrun_clr;

    modport master (
        output ext_strobe, din, coef_we, coef_addr, coef_wdata, overrun_clr,
        input  strobe_out, coef_ack, dout, out_valid, busy, overrun
    );

    modport slave (
        input  ext_strobe, din, coef_we, coef_addr, coef_wdata, overrun_clr,
        output strobe_out, coef_ack, dout, out_valid, busy, overrun
    );
endinterface

// File: rtl/fir_mac_serial.sv
// Serial-MAC FIR filter: one tap product per clock, offset-binary in and out,
// runtime-loadable taps, output saturation and a sticky overrun flag.
module fir_mac_serial #(
    parameter int DATA_W         = 12,
    parameter int OUT_W          = 12,
    parameter int COEF_W         = 16,
    parameter int COEF_FRAC      = 15,
    parameter int NTAPS          = 16,
    parameter int USE_EXT_STROBE = 0,
    parameter int SAMPLE_FACTOR  = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    fir_mac_serial_if.slave   bus
);
    localparam int AW    = $clog2(NTAPS);
    localparam int XW    = DATA_W + 1;
    localparam int PW    = XW + COEF_W;
    localparam int ACC_W = XW + COEF_W + $clog2(NTAPS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic strobe;

    generate
        if (USE_EXT_STROBE != 0) begin : g_ext_strobe
            assign strobe = bus.ext_strobe;
        end else begin : g_int_strobe
            localparam int DIV_W = (SAMPLE_FACTOR > 2) ? $clog2(SAMPLE_FACTOR) : 1;
            logic [DIV_W-1:0] div_reg;
            logic             strobe_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_reg    <= '0;
                    strobe_reg <= 1'b0;
                end else if (div_reg == DIV_W'(SAMPLE_FACTOR - 1)) begin
                    div_reg    <= '0;
                    strobe_reg <= 1'b1;
                end else begin
                    div_reg    <= div_reg + 1'b1;
                    strobe_reg <= 1'b0;
                end
            end

            assign strobe = strobe_reg;
        end
    endgenerate

    assign bus.strobe_out = strobe;

    // History and taps must clear on reset, so they live in flops rather than RAM.
    logic signed [XW-1:0]     hist_reg [NTAPS];
    logic signed [COEF_W-1:0] coef_reg [NTAPS];

    logic [1:0]              state_reg;
    logic [AW-1:0]           ptr_reg;
    logic [AW-1:0]           k_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [OUT_W-1:0]        dout_reg;
    logic                    out_valid_reg;
    logic                    overrun_reg;
    logic                    coef_ack_reg;

    logic                    busy;
    logic [AW-1:0]           ptr_next;
    logic [AW-1:0]           rd_idx;
    logic signed [XW-1:0]    x_new;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] y_full;
    logic [OUT_W-1:0]        y_sat;
    logic [OUT_W-1:0]        dout_next;

    // The out_valid cycle still counts as busy so a strobe there is dropped.
    assign busy     = (state_reg != S_IDLE) || out_valid_reg;
    assign ptr_next = (ptr_reg == AW'(NTAPS - 1)) ? '0 : ptr_reg + 1'b1;
    assign x_new    = $signed({1'b0, bus.din}) - $signed({2'b01, {(DATA_W-1){1'b0}}});

    always_comb begin
        rd_idx = ptr_reg - k_reg;
        if (ptr_reg < k_reg) begin
            rd_idx = AW'(NTAPS) + ptr_reg - k_reg;
        end
    end

    assign prod     = hist_reg[rd_idx] * coef_reg[k_reg];
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign y_full   = acc_reg >>> COEF_FRAC;

    always_comb begin
        y_sat = y_full[OUT_W-1:0];
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[OUT_W-1:0];
        end
    end

    // Two's complement to offset binary is an MSB flip.
    assign dout_next = {~y_sat[OUT_W-1], y_sat[OUT_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            dout_reg      <= {1'b1, {(OUT_W-1){1'b0}}};
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            coef_ack_reg  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                hist_reg[i] <= '0;
                coef_reg[i] <= '0;
            end
        end else begin
            out_valid_reg <= 1'b0;
            coef_ack_reg  <= 1'b0;

            if (strobe && busy) begin
                overrun_reg <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (strobe && !out_valid_reg) begin
                        hist_reg[ptr_next] <= x_new;
                        ptr_reg            <= ptr_next;
                        acc_reg            <= '0;
                        k_reg              <= '0;
                        state_reg          <= S_MAC;
                    end else if (bus.coef_we && !strobe &&
                                 (int'(bus.coef_addr) < NTAPS)) begin
                        coef_reg[bus.coef_addr] <= $signed(bus.coef_wdata);
                        coef_ack_reg            <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_reg <= acc_reg + prod_ext;
                    if (k_reg == AW'(NTAPS - 1)) begin
                        state_reg <= S_SCALE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_SCALE: begin
                    dout_reg      <= dout_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.dout      = dout_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun_reg;
    assign bus.coef_ack  = coef_ack_reg;
endmodule

// File: tb/tb_fir_mac_serial.sv
// Scoreboard bench for fir_mac_serial in external-strobe mode with 16 taps.
module tb_fir_mac_serial;
    localparam int NTAPS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_serial_if #(.DATA_W(12), .OUT_W(12), .COEF_W(16), .NTAPS(NTAPS)) bus ();

    fir_mac_serial #(
        .DATA_W(12), .OUT_W(12), .COEF_W(16), .COEF_FRAC(15), .NTAPS(NTAPS),
        .USE_EXT_STROBE(1), .SAMPLE_FACTOR(2000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] dout;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   hist_m[NTAPS];
    int   taps_m[NTAPS];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] model_out();
        longint acc = 0;
        longint y;
        for (int k = 0; k < NTAPS; k++) acc += longint'(hist_m[k]) * longint'(taps_m[k]);
        y = acc >>> 15;
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        return 12'(y + 2048);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: dout=%h at cycle %0d, none pending", bus.dout, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.dout !== e.dout || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: dout=%h cycle=%0d, required dout=%h cycle=%0d",
                             bus.dout, cyc, e.dout, e.cyc);
                end else begin
                    $display("ok   result: dout=%h cycle=%0d", bus.dout, cyc);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NTAPS; k++) begin
            hist_m[k] = 0;
            taps_m[k] = 0;
        end
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dout, bus.out_valid, bus.busy, bus.overrun, bus.coef_ack} !== {12'h800, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: dout=%h ov=%b busy=%b overrun=%b ack=%b, required 800/0/0/0/0",
                     bus.dout, bus.out_valid, bus.busy, bus.overrun, bus.coef_ack);
        end
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic write_coef(input int addr, input logic [15:0] val);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 4'(addr);
        bus.coef_wdata = val;
        @(negedge clk);
        bus.coef_we = 1'b0;
        checks++;
        if (bus.coef_ack !== 1'b1) begin
            errors++;
            $display("FAIL coef_ack: h[%0d] ack=%b, required 1", addr, bus.coef_ack);
        end else begin
            $display("ok   coef write h[%0d]=%h", addr, val);
        end
        taps_m[addr] = int'($signed(val));
    endtask

    // Called at a negedge; strobe is high for cycle T=cyc, returns at T+1.
    task automatic strobe(input logic [11:0] d, input bit accept);
        exp_t e;
        bus.din        = d;
        bus.ext_strobe = 1'b1;
        if (accept) begin
            for (int k = NTAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
            hist_m[0] = int'(d) - 2048;
            e.dout = model_out();
            e.cyc  = cyc + 18;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.ext_strobe = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b after 200 cycles", bus.busy);
        end
        tick(1);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic check_dout(input string name, input logic [11:0] req);
        checks++;
        if (bus.dout !== req) begin
            errors++;
            $display("FAIL %s: dout=%h, required %h", name, bus.dout, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        strobe(12'h123, 1'b1);
        check_bit("busy_t1", bus.busy, 1'b1);
        tick(17);
        check_bit("busy_t18", bus.busy, 1'b1);
        tick(1);
        check_bit("busy_t19", bus.busy, 1'b0);
        check_dout("zero_taps", 12'h800);
        check_drained("reset");
    endtask

    task automatic test_unity_tap();
        apply_reset();
        write_coef(0, 16'h7FFF);
        strobe(12'hC00, 1'b1);
        wait_idle();
        check_dout("unity_tap", 12'hBFF);
        check_drained("unity");
    endtask

    task automatic test_step();
        logic [11:0] req [6] = '{12'h900, 12'hA00, 12'hB00, 12'hC00, 12'hC00, 12'hC00};
        apply_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 16'h4000);
        for (int i = 0; i < 6; i++) begin
            strobe(12'hA00, 1'b1);
            tick(19);
            check_dout("step", req[i]);
            tick(1980);
        end
        check_drained("step");
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 16'h7FFF);
        for (int i = 0; i < 5; i++) begin
            strobe(12'hFFF, 1'b1);
            wait_idle();
        end
        check_dout("sat_high", 12'hFFF);
        for (int i = 0; i < 5; i++) begin
            strobe(12'h000, 1'b1);
            wait_idle();
        end
        check_dout("sat_low", 12'h000);
        check_drained("sat");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        write_coef(0, 16'h4000);
        write_coef(1, 16'h4000);
        strobe(12'h900, 1'b1);
        tick(4);
        check_bit("overrun_pre", bus.overrun, 1'b0);
        strobe(12'hF00, 1'b0);
        check_bit("overrun_set", bus.overrun, 1'b1);
        wait_idle();
        check_drained("overrun");
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check_bit("overrun_clr", bus.overrun, 1'b0);
        strobe(12'h900, 1'b1);
        tick(2);
        bus.overrun_clr = 1'b1;
        strobe(12'h100, 1'b0);
        bus.overrun_clr = 1'b0;
        check_bit("overrun_set_and_clr", bus.overrun, 1'b1);
        wait_idle();
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        strobe(12'hA00, 1'b1);
        tick(17);
        strobe(12'hABC, 1'b0);
        check_bit("overrun_outvalid_cycle", bus.overrun, 1'b1);
        strobe(12'h700, 1'b1);
        wait_idle();
        check_drained("back_to_back");
    endtask

    task automatic test_reset_midpass();
        apply_reset();
        write_coef(0, 16'h2000);
        write_coef(1, 16'h7FFF);
        strobe(12'hF00, 1'b1);
        tick(7);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dout, bus.out_valid, bus.busy} !== {12'h800, 2'b00}) begin
            errors++;
            $display("FAIL midpass_reset: dout=%h ov=%b busy=%b, required 800/0/0",
                     bus.dout, bus.out_valid, bus.busy);
        end
        clear_model();
        tick(2);
        rst_n = 1'b1;
        tick(30);
        write_coef(0, 16'h2000);
        write_coef(1, 16'h7FFF);
        strobe(12'h400, 1'b1);
        wait_idle();
        check_dout("history_zeroed", 12'h700);
        strobe(12'h400, 1'b1);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 4'd0;
        bus.coef_wdata = 16'h7FFF;
        @(negedge clk);
        bus.coef_we = 1'b0;
        check_bit("coef_ack_busy", bus.coef_ack, 1'b0);
        @(negedge clk);
        check_bit("coef_ack_busy_late", bus.coef_ack, 1'b0);
        wait_idle();
        strobe(12'h400, 1'b1);
        wait_idle();
        check_dout("tap_unchanged", 12'h300);
        check_drained("midpass");
    endtask

    initial begin
        bus.ext_strobe  = 1'b0;
        bus.din         = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_wdata  = '0;
        bus.overrun_clr = 1'b0;
        clear_model();
        test_reset();
        test_unity_tap();
        test_step();
        test_saturation();
        test_back_to_back();
        test_reset_midpass();
        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
